// File: rtl/pipe_pkg.sv
// Shared encodings for the MEM stage: EX/MEM control bit positions,
// the data-memory access FSM states and the timeout read-data default.
package pipe_pkg;

    localparam int M_BRANCH    = 2;
    localparam int M_READ      = 1;
    localparam int M_WRITE     = 0;
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears only the writeback control so
// that a stalled slot can never write the register file.
module mem_wb_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        bubble,
    input  logic [1:0]  wb,
    input  logic [31:0] rdata,
    input  logic [31:0] alures,
    input  logic [4:0]  rd,
    output logic [1:0]  wb_out,
    output logic [31:0] rdata_out,
    output logic [31:0] alures_out,
    output logic [4:0]  rd_out
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_out     <= 2'b00;
            rdata_out  <= 32'h0;
            alures_out <= 32'h0;
            rd_out     <= 5'd0;
        end else begin
            wb_out     <= bubble ? 2'b00 : wb;
            rdata_out  <= rdata;
            alures_out <= alures;
            rd_out     <= rd;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: branch resolution, handshaked data-memory access with a bus
// timeout, pipeline stall generation and the MEM/WB register.
module mem_wb_stage
    import pipe_pkg::*;
#(
    parameter int          TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  WB,
    input  logic [2:0]  M,
    input  logic [31:0] aluout1,
    input  logic [31:0] aluout2,
    input  logic        iszero,
    input  logic [31:0] wdata,
    input  logic [4:0]  mux5,
    output logic        PCSrc,
    output logic [31:0] pc_branch,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [1:0]  wb_out,
    output logic [31:0] rdata_out,
    output logic [31:0] alures_out,
    output logic [4:0]  rd_out,
    output logic        bus_err
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    mem_state_t  state;
    logic [15:0] cnt;
    logic [31:0] rd_reg;
    logic        mem_op;
    logic        is_read;
    logic [31:0] rdata_in;

    assign PCSrc     = M[M_BRANCH] & iszero;
    assign pc_branch = aluout1;

    // A read+write encoding is treated as a write, so it never returns data.
    assign mem_op  = M[M_READ] | M[M_WRITE];
    assign is_read = M[M_READ] & ~M[M_WRITE];
    assign stall   = mem_op && (state != DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 16'd0;
            rd_reg     <= 32'h0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_wdata <= 32'h0;
            bus_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        dmem_addr  <= aluout2;
                        dmem_wdata <= wdata;
                        dmem_we    <= M[M_WRITE];
                        dmem_req   <= 1'b1;
                        cnt        <= 16'd0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    // A response arriving on the last allowed cycle still wins.
                    if (dmem_ready) begin
                        rd_reg   <= dmem_rdata;
                        dmem_req <= 1'b0;
                        state    <= DONE;
                    end else if (cnt == TO_LAST) begin
                        rd_reg   <= ERR_DATA;
                        bus_err  <= 1'b1;
                        dmem_req <= 1'b0;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign rdata_in = (state == DONE && is_read) ? rd_reg : 32'h0;

    mem_wb_reg u_mem_wb_reg (
        .clk        (clk),
        .rst        (rst),
        .bubble     (stall),
        .wb         (WB),
        .rdata      (rdata_in),
        .alures     (aluout2),
        .rd         (mux5),
        .wb_out     (wb_out),
        .rdata_out  (rdata_out),
        .alures_out (alures_out),
        .rd_out     (rd_out)
    );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: stimulus queues expected MEM/WB contents,
// a monitor compares them after each clock edge.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  WB;
    logic [2:0]  M;
    logic [31:0] aluout1, aluout2, wdata, dmem_rdata;
    logic        iszero, dmem_ready;
    logic [4:0]  mux5;
    logic        PCSrc, stall, dmem_req, dmem_we, bus_err;
    logic [31:0] pc_branch, dmem_addr, dmem_wdata, rdata_out, alures_out;
    logic [1:0]  wb_out;
    logic [4:0]  rd_out;

    typedef struct {
        logic        full;
        logic [1:0]  wb;
        logic [31:0] rdata;
        logic [31:0] alures;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.TIMEOUT_CYC(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk        (clk),
        .rst        (rst),
        .WB         (WB),
        .M          (M),
        .aluout1    (aluout1),
        .aluout2    (aluout2),
        .iszero     (iszero),
        .wdata      (wdata),
        .mux5       (mux5),
        .PCSrc      (PCSrc),
        .pc_branch  (pc_branch),
        .stall      (stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .wb_out     (wb_out),
        .rdata_out  (rdata_out),
        .alures_out (alures_out),
        .rd_out     (rd_out),
        .bus_err    (bus_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] a1,
                                 input logic [31:0] a2, input logic z, input logic [31:0] wd,
                                 input logic [4:0] rd, input logic rdy, input logic [31:0] rdat);
        WB = wb; M = m; aluout1 = a1; aluout2 = a2; iszero = z;
        wdata = wd; mux5 = rd; dmem_ready = rdy; dmem_rdata = rdat;
    endtask

    task automatic pushExp(input logic full, input logic [1:0] wb, input logic [31:0] rdat,
                           input logic [31:0] alures, input logic [4:0] rd);
        exp_t e;
        e.full = full; e.wb = wb; e.rdata = rdat; e.alures = alures; e.rd = rd;
        sb.push_back(e);
    endtask

    // One complete memory op; ready_at=0 means the memory never answers.
    task automatic memOp(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input int ready_at,
                         input logic [31:0] rdat, input logic [31:0] exp_rdata, input logic exp_we);
        int busy_n;
        busy_n = (ready_at == 0) ? 4 : ready_at;
        applyStimulus(wb, m, 32'h0, addr, 1'b0, wd, rd, 1'b0, 32'h0);
        #1;
        checkOutput("idle_stall", stall, 1);
        checkOutput("idle_req", dmem_req, 0);
        pushExp(0, 2'b00, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        for (int i = 1; i <= busy_n; i++) begin
            dmem_ready = (i == ready_at);
            dmem_rdata = (i == ready_at) ? rdat : 32'h0;
            #1;
            checkOutput("busy_stall", stall, 1);
            checkOutput("busy_req", dmem_req, 1);
            checkOutput("busy_addr", dmem_addr, addr);
            checkOutput("busy_we", dmem_we, exp_we);
            checkOutput("busy_wdata", dmem_wdata, wd);
            pushExp(0, 2'b00, 32'h0, 32'h0, 5'd0);
            @(negedge clk);
        end
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        #1;
        checkOutput("done_stall", stall, 0);
        checkOutput("done_req", dmem_req, 0);
        pushExp(1, wb, exp_rdata, addr, rd);
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst && sb.size() > 0) begin
                mon_e = sb.pop_front();
                checkOutput("mw_wb", wb_out, mon_e.wb);
                checkOutput("mw_rdata", rdata_out, mon_e.rdata);
                if (mon_e.full) begin
                    checkOutput("mw_alures", alures_out, mon_e.alures);
                    checkOutput("mw_rd", rd_out, mon_e.rd);
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        applyStimulus(2'b00, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_wb", wb_out, 0);
        checkOutput("rst_rdata", rdata_out, 0);
        checkOutput("rst_alures", alures_out, 0);
        checkOutput("rst_rd", rd_out, 0);
        checkOutput("rst_req", dmem_req, 0);
        checkOutput("rst_addr", dmem_addr, 0);
        checkOutput("rst_buserr", bus_err, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(2'b10, 3'b000, 32'h0, 32'h10, 1'b0, 32'h0, 5'd3, 1'b0, 32'h0);
        #1;
        checkOutput("alu_stall", stall, 0);
        pushExp(1, 2'b10, 32'h0, 32'h10, 5'd3);
        @(negedge clk);

        memOp(2'b11, 3'b010, 32'h40, 32'h0, 5'd5, 1, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0);
        memOp(2'b00, 3'b001, 32'h80, 32'h1234_5678, 5'd0, 4, 32'h0, 32'h0, 1'b1);
        checkOutput("store_late_buserr", bus_err, 0);
        memOp(2'b01, 3'b011, 32'h90, 32'hA5A5_A5A5, 5'd7, 2, 32'h5555_5555, 32'h0, 1'b1);

        applyStimulus(2'b00, 3'b100, 32'h200, 32'h5, 1'b1, 32'h0, 5'd0, 1'b0, 32'h0);
        #1;
        checkOutput("br_pcsrc", PCSrc, 1);
        checkOutput("br_target", pc_branch, 32'h200);
        checkOutput("br_stall", stall, 0);
        pushExp(1, 2'b00, 32'h0, 32'h5, 5'd0);
        @(negedge clk);
        applyStimulus(2'b00, 3'b100, 32'h300, 32'h6, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        #1;
        checkOutput("nbr_pcsrc", PCSrc, 0);
        checkOutput("nbr_target", pc_branch, 32'h300);
        pushExp(1, 2'b00, 32'h0, 32'h6, 5'd0);
        @(negedge clk);

        // A stray ready while idle must not start anything.
        applyStimulus(2'b10, 3'b000, 32'h0, 32'h20, 1'b0, 32'h0, 5'd4, 1'b1, 32'h1111_1111);
        pushExp(1, 2'b10, 32'h0, 32'h20, 5'd4);
        @(negedge clk);
        applyStimulus(2'b00, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        #1;
        checkOutput("stray_req", dmem_req, 0);
        pushExp(1, 2'b00, 32'h0, 32'h0, 5'd0);
        @(negedge clk);

        memOp(2'b11, 3'b010, 32'h44, 32'h0, 5'd9, 0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        checkOutput("to_buserr", bus_err, 1);
        memOp(2'b11, 3'b010, 32'h4C, 32'h0, 5'd10, 1, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0);
        checkOutput("sticky_buserr", bus_err, 1);

        applyStimulus(2'b11, 3'b010, 32'h0, 32'h48, 1'b0, 32'h0, 5'd11, 1'b0, 32'h0);
        pushExp(0, 2'b00, 32'h0, 32'h0, 5'd0);
        @(posedge clk);
        #2;
        checkOutput("prerst_req", dmem_req, 1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_req", dmem_req, 0);
        checkOutput("midrst_alures", alures_out, 0);
        checkOutput("midrst_rd", rd_out, 0);
        checkOutput("midrst_wb", wb_out, 0);
        checkOutput("midrst_buserr", bus_err, 0);
        applyStimulus(2'b00, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        #1;
        checkOutput("midrst_stall", stall, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        memOp(2'b11, 3'b010, 32'h50, 32'h0, 5'd12, 1, 32'h7777_0000, 32'h7777_0000, 1'b0);
        checkOutput("post_rst_buserr", bus_err, 0);

        for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
